// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the dm_responder data-memory responder.
//   dm_state_e : responder FSM states (IDLE, WAIT, RESP)
//   CNT_W      : width of the latency down-counter
//   dm_merge() : byte-lane merge of store data into an existing word
package dm_pkg;

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dm_state_e;

   // Lane i of i_new replaces lane i of i_old where i_be[i] is set.
   function automatic logic [31:0] dm_merge(input logic [31:0] i_old,
                                            input logic [31:0] i_new,
                                            input logic [3:0]  i_be);
      logic [31:0] w_res;
      w_res = i_old;
      for (int i = 0; i < 4; i++) begin
         if (i_be[i]) w_res[8*i +: 8] = i_new[8*i +: 8];
      end
      return w_res;
   endfunction

endpackage

// File: rtl/dm_ram_array.sv
// dm_ram_array: word array behind dm_responder.
//   i_clk, i_rst       : clock, synchronous active-high clear of every word
//   i_we, i_waddr,
//   i_wdata, i_be      : single write port with per-byte-lane enables
//   i_raddr, o_rdata   : combinational read port (reads 0 past the end)
module dm_ram_array
   import dm_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 3072,
   parameter int unsigned AW          = 12
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [31:0]   i_wdata,
   input  logic [3:0]    i_be,
   input  logic [AW-1:0] i_raddr,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [DEPTH_WORDS];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < int'(DEPTH_WORDS); i++) r_mem[i] <= '0;
      end else if (i_we && (32'(i_waddr) < DEPTH_WORDS)) begin
         r_mem[i_waddr] <= dm_merge(r_mem[i_waddr], i_wdata, i_be);
      end
   end

   assign o_rdata = (32'(i_raddr) < DEPTH_WORDS) ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/dm_responder.sv
// dm_responder: single-outstanding data-memory responder with fixed latency.
//   clk, rst                : clock, synchronous active-high reset
//   req_valid/req_ready     : request handshake (ready only while IDLE)
//   req_we, req_addr,
//   req_wdata, req_be       : store/load, byte address, store data, byte enables
//   req_pc                  : issuing PC, used only by the write trace
//   rsp_valid/rsp_ready     : response handshake
//   rsp_rdata, rsp_err      : load data (0 for stores), out-of-range flag
//   busy                    : FSM not IDLE
// Optional feature: define DM_WRITE_TRACE_EN to print each executed in-range store.
module dm_responder
   import dm_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 3072,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   input  logic [31:0] req_pc,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   localparam int unsigned AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam bit          LAT1 = (LATENCY == 1);

   dm_state_e        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_we;
   logic [29:0]      r_idx;
   logic [31:0]      r_wdata;
   logic [3:0]       r_be;
   logic             r_req_ready;
   logic             r_rsp_valid;
   logic [31:0]      r_rsp_rdata;
   logic             r_rsp_err;
   logic             r_busy;

   logic        w_exec;
   logic        w_exec_we;
   logic [29:0] w_exec_idx;
   logic [31:0] w_exec_wdata;
   logic [3:0]  w_exec_be;
   logic        w_in_range;
   logic [31:0] w_rdata;
   logic [31:0] w_rsp_rdata;
   logic        w_unused_addr;

   // With LATENCY=1 the access executes on the accept edge straight from the
   // request inputs; otherwise it uses the operands latched at accept.
   assign w_exec_we    = (r_state == IDLE) ? req_we         : r_we;
   assign w_exec_idx   = (r_state == IDLE) ? req_addr[31:2] : r_idx;
   assign w_exec_wdata = (r_state == IDLE) ? req_wdata      : r_wdata;
   assign w_exec_be    = (r_state == IDLE) ? req_be         : r_be;

   assign w_exec = !rst && (((r_state == IDLE) && req_valid && LAT1) ||
                            ((r_state == WAIT) && (r_cnt == CNT_W'(1))));

   assign w_in_range  = ({2'b00, w_exec_idx} < DEPTH_WORDS);
   assign w_rsp_rdata = (w_exec_we || !w_in_range) ? 32'h0 : w_rdata;

   dm_ram_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_ram (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_we    (w_exec && w_exec_we && w_in_range),
      .i_waddr (w_exec_idx[AW-1:0]),
      .i_wdata (w_exec_wdata),
      .i_be    (w_exec_be),
      .i_raddr (w_exec_idx[AW-1:0]),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_we        <= req_we;
                  r_idx       <= req_addr[31:2];
                  r_wdata     <= req_wdata;
                  r_be        <= req_be;
                  r_req_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  if (LAT1) begin
                     r_state     <= RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_rdata <= w_rsp_rdata;
                     r_rsp_err   <= !w_in_range;
                  end else begin
                     r_state <= WAIT;
                     r_cnt   <= CNT_W'(LATENCY - 1);
                  end
               end
            end
            WAIT: begin
               r_cnt <= r_cnt - CNT_W'(1);
               if (w_exec) begin
                  r_state     <= RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_rdata <= w_rsp_rdata;
                  r_rsp_err   <= !w_in_range;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  r_state     <= IDLE;
                  r_rsp_valid <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign busy      = r_busy;

   assign w_unused_addr = ^req_addr[1:0];

`ifdef DM_WRITE_TRACE_EN
   logic [31:0] r_pc;
   logic [31:0] w_exec_pc;

   always_ff @(posedge clk) begin
      if (!rst && (r_state == IDLE) && req_valid) r_pc <= req_pc;
   end

   assign w_exec_pc = (r_state == IDLE) ? req_pc : r_pc;

   always @(posedge clk) begin
      if (w_exec && w_exec_we && w_in_range) begin
         $display("@%08h: *%08h <= %08h", w_exec_pc, {w_exec_idx, 2'b00},
                  dm_merge(w_rdata, w_exec_wdata, w_exec_be));
      end
   end
`else
   logic w_unused_pc;
   assign w_unused_pc = ^req_pc;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: three instances with LATENCY = 1, 2, 3 (index k -> LATENCY k+1),
// checked against a word-array model of the memory and the latency/handshake rules.
module tb_dm_responder;

   localparam int NI    = 3;
   localparam int DEPTH = 3072;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst       [NI];
   logic        req_valid [NI];
   logic        req_ready [NI];
   logic        req_we    [NI];
   logic [31:0] req_addr  [NI];
   logic [31:0] req_wdata [NI];
   logic [3:0]  req_be    [NI];
   logic [31:0] req_pc    [NI];
   logic        rsp_valid [NI];
   logic        rsp_ready [NI];
   logic [31:0] rsp_rdata [NI];
   logic        rsp_err   [NI];
   logic        busy      [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      dm_responder #(
         .DEPTH_WORDS (DEPTH),
         .LATENCY     (g + 1)
      ) u_dut (
         .clk       (clk),
         .rst       (rst[g]),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_we    (req_we[g]),
         .req_addr  (req_addr[g]),
         .req_wdata (req_wdata[g]),
         .req_be    (req_be[g]),
         .req_pc    (req_pc[g]),
         .rsp_valid (rsp_valid[g]),
         .rsp_ready (rsp_ready[g]),
         .rsp_rdata (rsp_rdata[g]),
         .rsp_err   (rsp_err[g]),
         .busy      (busy[g])
      );
   end

   logic [31:0] mdl [NI][DEPTH];
   int n_chk = 0;
   int n_err = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model(input int k);
      for (int i = 0; i < DEPTH; i++) mdl[k][i] = 32'h0;
   endtask

   task automatic check_idle(input int k, input string tag);
      n_chk++;
      if (req_ready[k] !== 1'b1 || rsp_valid[k] !== 1'b0 || busy[k] !== 1'b0) begin
         n_err++;
         $display("FAIL %s k=%0d: got ready=%b valid=%b busy=%b required 1 0 0",
                  tag, k, req_ready[k], rsp_valid[k], busy[k]);
      end
   endtask

   // One request end to end: latency, data, error flag, optional stall window
   // with an intruding request, then the response handshake.
   task automatic do_req(input int k, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input int hold, input bit intrude, output logic [31:0] got);
      int          t0;
      int          budget;
      int          idx;
      bit          inr;
      logic [31:0] exp_d;
      idx = int'(addr[31:2]);
      inr = (idx < DEPTH);
      exp_d = (we || !inr) ? 32'h0 : mdl[k][idx];
      if (we && inr) begin
         for (int i = 0; i < 4; i++) if (be[i]) mdl[k][idx][8*i +: 8] = wdata[8*i +: 8];
      end
      budget = 0;
      while (req_ready[k] !== 1'b1 && budget < 20) begin step(); budget++; end
      req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = addr;
      req_wdata[k] = wdata; req_be[k] = be; req_pc[k] = $urandom;
      t0 = cyc;
      step();
      req_valid[k] = 1'b0;
      budget = 0;
      while (rsp_valid[k] !== 1'b1 && budget < 20) begin step(); budget++; end
      n_chk++;
      if (cyc - t0 != k + 1) begin
         n_err++;
         $display("FAIL latency k=%0d addr=%h: got %0d cycles required %0d", k, addr, cyc - t0, k + 1);
      end
      n_chk++;
      if (rsp_rdata[k] !== exp_d || rsp_err[k] !== !inr) begin
         n_err++;
         $display("FAIL rsp k=%0d addr=%h: got data=%h err=%b required data=%h err=%b",
                  k, addr, rsp_rdata[k], rsp_err[k], exp_d, !inr);
      end
      got = rsp_rdata[k];
      for (int h = 0; h < hold; h++) begin
         if (intrude) begin
            req_valid[k] = 1'b1; req_we[k] = 1'b1; req_addr[k] = 32'h20;
            req_wdata[k] = 32'hDEAD_BEEF; req_be[k] = 4'hF;
         end
         step();
         n_chk++;
         if (rsp_valid[k] !== 1'b1 || rsp_rdata[k] !== exp_d || req_ready[k] !== 1'b0 ||
             busy[k] !== 1'b1) begin
            n_err++;
            $display("FAIL stall k=%0d cyc=%0d: got valid=%b data=%h ready=%b busy=%b required 1 %h 0 1",
                     k, h, rsp_valid[k], rsp_rdata[k], req_ready[k], busy[k], exp_d);
         end
      end
      req_valid[k] = 1'b0;
      rsp_ready[k] = 1'b1;
      step();
      rsp_ready[k] = 1'b0;
      check_idle(k, "after_handshake");
   endtask

   task automatic test_reset();
      for (int k = 0; k < NI; k++) begin
         rst[k] = 1'b1; req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
         req_wdata[k] = '0; req_be[k] = '0; req_pc[k] = '0; rsp_ready[k] = 1'b0;
         clear_model(k);
      end
      step(); step();
      for (int k = 0; k < NI; k++) rst[k] = 1'b0;
      for (int k = 0; k < NI; k++) begin
         check_idle(k, "reset_state");
         n_chk++;
         if (rsp_rdata[k] !== 32'h0 || rsp_err[k] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_rsp k=%0d: got data=%h err=%b required 0 0", k, rsp_rdata[k], rsp_err[k]);
         end
      end
   endtask

   task automatic test_store_load();
      logic [31:0] got;
      do_req(1, 1'b1, 32'h4, 32'h1234_5678, 4'hF, 0, 1'b0, got);
      do_req(1, 1'b0, 32'h4, 32'h0, 4'h0, 0, 1'b0, got);
      n_chk++;
      if (got !== 32'h1234_5678) begin
         n_err++; $display("FAIL store_load: got %h required 12345678", got);
      end
   endtask

   task automatic test_byte_merge();
      logic [31:0] got;
      do_req(1, 1'b1, 32'h8, 32'hAABB_CCDD, 4'hF, 0, 1'b0, got);
      do_req(1, 1'b1, 32'h8, 32'h0000_00EE, 4'h1, 0, 1'b0, got);
      do_req(1, 1'b0, 32'h8, 32'h0, 4'h0, 0, 1'b0, got);
      n_chk++;
      if (got !== 32'hAABB_CCEE) begin
         n_err++; $display("FAIL byte_merge: got %h required aabbccee", got);
      end
      do_req(1, 1'b1, 32'h8, 32'h5555_5555, 4'h0, 0, 1'b0, got);
      do_req(1, 1'b0, 32'h8, 32'h0, 4'h0, 0, 1'b0, got);
      n_chk++;
      if (got !== 32'hAABB_CCEE) begin
         n_err++; $display("FAIL be_zero: got %h required aabbccee", got);
      end
   endtask

   task automatic test_out_of_range();
      logic [31:0] got;
      do_req(1, 1'b1, 32'h2FFC, 32'h0F0F_1234, 4'hF, 0, 1'b0, got);
      do_req(1, 1'b0, 32'h3000, 32'h0, 4'h0, 0, 1'b0, got);
      do_req(1, 1'b1, 32'h3000, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, got);
      do_req(1, 1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, got);
      do_req(1, 1'b0, 32'h2FFC, 32'h0, 4'h0, 0, 1'b0, got);
      do_req(1, 1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, got);
      do_req(1, 1'b0, 32'h4, 32'h0, 4'h0, 0, 1'b0, got);
      do_req(1, 1'b0, 32'h3FF0, 32'h0, 4'h0, 0, 1'b0, got);
   endtask

   task automatic test_stall();
      logic [31:0] got;
      do_req(1, 1'b0, 32'h4, 32'h0, 4'h0, 5, 1'b1, got);
      do_req(1, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, got);
      n_chk++;
      if (got !== 32'h0) begin
         n_err++; $display("FAIL stall_intrude: got %h required 00000000", got);
      end
   endtask

   task automatic test_reset_abort();
      logic [31:0] got;
      do_req(2, 1'b1, 32'h14, 32'h7777_8888, 4'hF, 0, 1'b0, got);
      req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h10;
      req_wdata[2] = 32'hCAFE_BABE; req_be[2] = 4'hF;
      step();
      req_valid[2] = 1'b0;
      rst[2] = 1'b1;
      step();
      rst[2] = 1'b0;
      clear_model(2);
      for (int c = 0; c < 5; c++) begin
         check_idle(2, "abort_idle");
         n_chk++;
         if (rsp_rdata[2] !== 32'h0 || rsp_err[2] !== 1'b0) begin
            n_err++;
            $display("FAIL abort_rsp: got data=%h err=%b required 0 0", rsp_rdata[2], rsp_err[2]);
         end
         step();
      end
      do_req(2, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, got);
      n_chk++;
      if (got !== 32'h0) begin
         n_err++; $display("FAIL abort_load10: got %h required 00000000", got);
      end
      do_req(2, 1'b0, 32'h14, 32'h0, 4'h0, 0, 1'b0, got);
   endtask

   task automatic test_back_to_back();
      logic [31:0] got;
      do_req(0, 1'b1, 32'h30, 32'h0BAD_F00D, 4'hF, 0, 1'b0, got);
      rsp_ready[0] = 1'b1;
      req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h30;
      step();
      n_chk++;
      if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'h0BAD_F00D) begin
         n_err++;
         $display("FAIL b2b_first: got valid=%b data=%h required 1 0badf00d", rsp_valid[0], rsp_rdata[0]);
      end
      req_we[0] = 1'b1; req_addr[0] = 32'h34; req_wdata[0] = 32'h1111_2222; req_be[0] = 4'hF;
      mdl[0][13] = 32'h1111_2222;
      step();
      check_idle(0, "b2b_no_same_edge_accept");
      step();
      n_chk++;
      if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'h0) begin
         n_err++;
         $display("FAIL b2b_second: got valid=%b data=%h required 1 00000000", rsp_valid[0], rsp_rdata[0]);
      end
      req_we[0] = 1'b0;
      step();
      check_idle(0, "b2b_gap");
      step();
      n_chk++;
      if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'h1111_2222) begin
         n_err++;
         $display("FAIL b2b_third: got valid=%b data=%h required 1 11112222", rsp_valid[0], rsp_rdata[0]);
      end
      req_valid[0] = 1'b0;
      step();
      rsp_ready[0] = 1'b0;
      check_idle(0, "b2b_end");
   endtask

   task automatic test_random();
      logic [31:0] got;
      logic [31:0] addr;
      for (int k = 0; k < NI; k++) begin
         for (int n = 0; n < 30; n++) begin
            if ($urandom_range(7) == 0) addr = 32'h3000 + 32'($urandom_range(3)) * 4;
            else                        addr = 32'($urandom_range(7)) * 4 + 32'($urandom_range(3));
            do_req(k, 1'($urandom_range(1)), addr, $urandom, 4'($urandom_range(15)),
                   $urandom_range(2), 1'b0, got);
            for (int p = $urandom_range(2); p > 0; p--) step();
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_store_load();
      test_byte_merge();
      test_out_of_range();
      test_stall();
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
